// File: rtl/spi_cmd_queue.sv
// Command queue in front of an SPI master: buffers 40-bit frames, launches them one at a
// time with a minimum idle gap, returns each received byte and aborts hung transfers.
module spi_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [39:0]                cmd_data,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  output logic                       spi_start,
  output logic [39:0]                spi_data_in,
  input  logic                       spi_busy,
  input  logic                       spi_new_data,
  input  logic [7:0]                 spi_data_out,
  output logic [7:0]                 rsp_data,
  output logic                       rsp_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       idle,
  output logic                       err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0]   GAP_LAST = 16'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
  } state_t;

  state_t        state;
  logic [39:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   cnt;
  logic          push;
  logic          pop;
  logic          done;
  logic          wd_abort;
  logic          busy_abort;

  assign cmd_ready  = rst && (level != FULL_LVL);
  assign push       = cmd_valid && cmd_ready;
  assign done       = (state == S_WAIT_DONE) && spi_new_data;
  assign wd_abort   = (state == S_WAIT_DONE) && !spi_new_data && (cnt == TO_LAST);
  // Master never raised busy within two cycles of the start pulse.
  assign busy_abort = (state == S_WAIT_BUSY) && !spi_busy && (cnt == 16'd1);
  assign pop        = done || wd_abort || busy_abort;
  assign idle       = (level == '0) && (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      cnt         <= '0;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      spi_start <= 1'b0;
      rsp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          // Head is latched here and held until the next launch.
          if ((level != '0) && !spi_busy) begin
            spi_data_in <= mem[rd_ptr];
            spi_start   <= 1'b1;
            state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (spi_busy) begin
            cnt   <= '0;
            state <= S_WAIT_DONE;
          end else if (busy_abort) begin
            err_timeout <= 1'b1;
            cnt         <= '0;
            state       <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (done) begin
            rsp_data  <= spi_data_out;
            rsp_valid <= 1'b1;
            cnt       <= '0;
            state     <= S_GAP;
          end else if (wd_abort) begin
            err_timeout <= 1'b1;
            cnt         <= '0;
            state       <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt >= GAP_LAST) state <= S_IDLE;
          else                 cnt   <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Directed bench for spi_cmd_queue with a small behavioural SPI master model that answers
// each frame with its low byte XOR 0x99.
module tb_spi_cmd_queue;

  localparam int DEPTH   = 4;
  localparam int GAP_CYC = 4;
  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        spi_start;
  logic [39:0] spi_data_in;
  logic        spi_busy;
  logic        spi_new_data;
  logic [7:0]  spi_data_out;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic [2:0]  level;
  logic        idle;
  logic        err_timeout;

  spi_cmd_queue #(.DEPTH(DEPTH), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_busy     (spi_busy),
    .spi_new_data (spi_new_data),
    .spi_data_out (spi_data_out),
    .rsp_data     (rsp_data),
    .rsp_valid    (rsp_valid),
    .level        (level),
    .idle         (idle),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master model: busy the edge after start, done pulse after a short transfer.
  logic        hang;
  logic        stray_nd;
  logic        sl_busy = 1'b0;
  logic        sl_nd = 1'b0;
  logic [39:0] sl_frame = '0;
  int          sl_cnt = 0;
  int          start_busy_viol = 0;

  assign spi_busy     = sl_busy;
  assign spi_new_data = sl_nd | stray_nd;

  initial spi_data_out = '0;

  always @(negedge clk) begin
    sl_nd = 1'b0;
    if (!rst) begin
      sl_busy = 1'b0;
      sl_cnt  = 0;
    end else if (sl_busy) begin
      if (spi_start) start_busy_viol++;
      if (!hang) begin
        if (sl_cnt == 0) begin
          sl_nd        = 1'b1;
          spi_data_out = sl_frame[7:0] ^ 8'h99;
          sl_busy      = 1'b0;
        end else begin
          sl_cnt--;
        end
      end
    end else if (spi_start) begin
      sl_busy  = 1'b1;
      sl_cnt   = 3;
      sl_frame = spi_data_in;
    end
  end

  // Output monitor, sampled just after each rising edge.
  int         cyc = 0;
  int         n_start = 0;
  int         last_nd = -1;
  logic [7:0] rsp_log [$];
  int         gap_log [$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (spi_start) begin
      n_start++;
      if (last_nd >= 0) gap_log.push_back(cyc - last_nd);
    end
    if (spi_new_data) last_nd = cyc;
    if (rsp_valid) rsp_log.push_back(rsp_data);
  end

  task automatic push_frame(input logic [39:0] d);
    int k = 0;
    @(negedge clk);
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("push_accept", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (rsp_log.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_count", rsp_log.size(), n);
  endtask

  initial begin
    logic [7:0] exp_t2 [6];
    int g0, k, k2, ns;
    exp_t2 = '{8'h98, 8'h9B, 8'h9A, 8'h9D, 8'h9C, 8'h9F};
    rst = 1'b0; cmd_valid = 1'b0; cmd_data = '0; hang = 1'b0; stray_nd = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_idle", idle, 1);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_spi_data_in", spi_data_in, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    // T1: single frame, launch latency and response
    push_frame(40'h00000000A5);
    chk("t1_level", level, 1);
    chk("t1_no_start_yet", spi_start, 0);
    chk("t1_not_idle", idle, 0);
    @(posedge clk); #1;
    chk("t1_start", spi_start, 1);
    chk("t1_data_in", spi_data_in, 40'h00000000A5);
    @(posedge clk); #1;
    chk("t1_start_one_cycle", spi_start, 0);
    wait_rsp(1);
    chk("t1_rsp", rsp_log[0], 8'h3C);
    repeat (3) @(negedge clk);
    chk("t1_single_rsp", rsp_log.size(), 1);
    chk("t1_single_start", n_start, 1);

    // T2/T3: fill the queue, push into the slot freed by a pop, then push and pop together
    g0 = gap_log.size();
    for (int i = 1; i <= 4; i++) push_frame(40'h1122334400 | 40'(i));
    chk("t2_full_level", level, 4);
    chk("t2_full_ready", cmd_ready, 0);
    push_frame(40'h1122334405);
    chk("t3_refill_level", level, 4);
    k = 0;
    do begin
      @(negedge clk); #2; k++;
    end while (!(spi_new_data && level == 3) && k < 200);
    chk("t3_pushpop_ready", cmd_ready, 1);
    cmd_data = 40'h1122334406; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    chk("t3_pushpop_level", level, 3);
    wait_rsp(7);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_rsp%0d", i), rsp_log[i+1], exp_t2[i]);
    chk("t2_gap_entries", gap_log.size() - g0, 6);
    for (int i = g0; i < gap_log.size(); i++)
      chk($sformatf("t2_gap%0d", i - g0), gap_log[i] >= GAP_CYC, 1);
    chk("t2_starts", n_start, 7);

    // T6: stray done pulses in IDLE and in GAP
    @(negedge clk); stray_nd = 1'b1;
    @(negedge clk); stray_nd = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle_rsp", rsp_log.size(), 7);
    chk("t6_idle_level", level, 0);
    chk("t6_idle", idle, 1);
    push_frame(40'h0000000010);
    push_frame(40'h0000000020);
    wait_rsp(8);
    @(negedge clk); stray_nd = 1'b1;
    @(negedge clk); stray_nd = 1'b0;
    chk("t6_gap_level", level, 1);
    wait_rsp(9);
    chk("t6_rsp_a", rsp_log[7], 8'h89);
    chk("t6_rsp_b", rsp_log[8], 8'hB9);
    repeat (12) @(negedge clk);
    chk("t6_no_extra_rsp", rsp_log.size(), 9);

    // T4: hung transfer, watchdog abort, next frame still served
    hang = 1'b1;
    push_frame(40'h0000000077);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!spi_start && k < 50);
    chk("t4_started", spi_start, 1);
    k2 = 0;
    do begin @(posedge clk); #1; k2++; end while (!err_timeout && k2 < 6000);
    chk("t4_abort_cycles", k2, TIMEOUT + 2);
    chk("t4_err", err_timeout, 1);
    chk("t4_popped", level, 0);
    hang = 1'b0;
    push_frame(40'h0000000055);
    wait_rsp(10);
    chk("t4_next_rsp", rsp_log[9], 8'hCC);
    chk("t4_err_sticky", err_timeout, 1);

    // T5: reset while waiting for done with three frames held
    hang = 1'b1;
    push_frame(40'h0000000031);
    push_frame(40'h0000000032);
    push_frame(40'h0000000033);
    repeat (20) @(negedge clk);
    chk("t5_level_before", level, 3);
    ns = n_start;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_level", level, 0);
    chk("t5_idle", idle, 1);
    chk("t5_start", spi_start, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_err_clr", err_timeout, 0);
    chk("t5_ready", cmd_ready, 0);
    hang = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_still_empty", level, 0);
    chk("t5_no_launch", n_start, ns);
    chk("t5_no_rsp", rsp_log.size(), 10);

    chk("start_while_busy", start_busy_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got sim time %0t required completion earlier", $time);
    $fatal(1);
  end

endmodule
